// File: rtl/lifo_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lifo_stack_pkg
// Brief    : Shared sizing helpers for the LIFO stack.
// Revision : 1.0 - initial release
// ============================================================================
package lifo_stack_pkg;

    // Pointer must count 0..depth inclusive, hence the extra bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : lifo_stack_pkg
`default_nettype wire

// File: rtl/lifo_stack.sv
`default_nettype none
// ============================================================================
// Module   : lifo_stack
// Brief    : Synchronous LIFO with single-cycle push/pop, full/empty flags
//            and an exposed entry-count pointer.
// Revision : 1.0 - initial release
// ============================================================================
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter int data_width = 8,
    parameter int stack_size = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  logic                              pop,
    input  logic [data_width-1:0]             data_in,
    output logic [data_width-1:0]             data_out,
    output logic                              full,
    output logic                              empty,
    output logic [ptr_width(stack_size)-1:0]  ptr
);

    localparam int PTR_W = ptr_width(stack_size);
    localparam int IDX_W = idx_width(stack_size);
    localparam logic [PTR_W-1:0] c_depth = PTR_W'(stack_size);
    localparam logic [PTR_W-1:0] c_one   = PTR_W'(1);

    logic [data_width-1:0] mem [0:stack_size-1];

    logic [PTR_W-1:0]      r_ptr;
    logic [data_width-1:0] r_data_out;
    logic [PTR_W-1:0]      w_ptr_dec;
    logic                  w_full;
    logic                  w_empty;

    assign w_full    = (r_ptr == c_depth);
    assign w_empty   = (r_ptr == '0);
    assign w_ptr_dec = r_ptr - c_one;

    // Push wins over a simultaneous pop; the pop is dropped entirely.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr      <= '0;
            r_data_out <= '0;
        end else if (push) begin
            if (!w_full) begin
                mem[r_ptr[IDX_W-1:0]] <= data_in;
                r_ptr                 <= r_ptr + c_one;
            end
        end else if (pop && !w_empty) begin
            r_data_out <= mem[w_ptr_dec[IDX_W-1:0]];
            r_ptr      <= w_ptr_dec;
        end
    end

    assign data_out = r_data_out;
    assign full     = w_full;
    assign empty    = w_empty;
    assign ptr      = r_ptr;

endmodule : lifo_stack
`default_nettype wire

// File: tb/tb_lifo_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_lifo_stack
// Brief    : Directed self-checking bench for lifo_stack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lifo_stack;

    localparam int DW = 8;
    localparam int SS = 8;
    localparam int PW = $clog2(SS) + 1;

    logic          clk;
    logic          rst;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic [PW-1:0] ptr;

    int n_checks = 0;
    int n_fails  = 0;

    lifo_stack #(.data_width(DW), .stack_size(SS)) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .ptr      (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic pu, input logic po, input logic [DW-1:0] d);
        @(negedge clk);
        rst = r; push = pu; pop = po; data_in = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mem_at(input int i);
        return dut.mem[i];
    endfunction

    initial begin
        logic [DW-1:0] vals [3];
        int exp_ptr;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        rst = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_ptr",   32'(ptr),      32'd0);
        check("rst_empty", 32'(empty),    32'd1);
        check("rst_full",  32'(full),     32'd0);
        check("rst_dout",  32'(data_out), 32'h00);

        // Push 11,22,33 then pop them back in reverse
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, vals[i]);
            check("push3_ptr", 32'(ptr), 32'(i + 1));
            check("push3_top", 32'(mem_at(i)), 32'(vals[i]));
        end
        for (int i = 2; i >= 0; i--) begin
            step(1'b1, 1'b0, 1'b1, 8'h00);
            check("pop3_dout", 32'(data_out), 32'(vals[i]));
            check("pop3_ptr",  32'(ptr), 32'(i));
        end
        check("pop3_empty", 32'(empty), 32'd1);

        // Single push/pop round trip
        step(1'b1, 1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check("rt_dout", 32'(data_out), 32'h55);
        check("rt_ptr",  32'(ptr), 32'd0);

        // Overfill with FF, then overdrain
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'hFF);
            exp_ptr = (i + 1 < SS) ? i + 1 : SS;
            check("fill_ptr",  32'(ptr), 32'(exp_ptr));
            check("fill_full", 32'(full), 32'(exp_ptr == SS));
            check("fill_top",  32'(mem_at(exp_ptr - 1)), 32'hFF);
        end
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00);
            exp_ptr = (SS - i - 1 > 0) ? SS - i - 1 : 0;
            check("drain_ptr",  32'(ptr), 32'(exp_ptr));
            check("drain_dout", 32'(data_out), 32'hFF);
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_full",  32'(full),  32'd0);

        // Push after drain
        step(1'b1, 1'b1, 1'b0, 8'h11);
        check("post_ptr",   32'(ptr), 32'd1);
        check("post_mem0",  32'(mem_at(0)), 32'h11);
        check("post_empty", 32'(empty), 32'd0);

        // Simultaneous push/pop on a one-entry stack
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'hAA);
        step(1'b1, 1'b1, 1'b1, 8'h5C);
        check("pp_ptr",  32'(ptr), 32'd2);
        check("pp_mem1", 32'(mem_at(1)), 32'h5C);
        check("pp_mem0", 32'(mem_at(0)), 32'hAA);
        check("pp_dout", 32'(data_out), 32'h00);

        // Reset while partially full
        step(1'b1, 1'b1, 1'b0, 8'h77);
        check("mid_ptr", 32'(ptr), 32'd3);
        step(1'b0, 1'b1, 1'b0, 8'h99);
        check("mid_rst_ptr",   32'(ptr), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);

        // Full stack: no overwrite on push, push+pop behaves as ignored push
        for (int i = 0; i < SS; i++) step(1'b1, 1'b1, 1'b0, 8'(i + 1));
        check("full_flag", 32'(full), 32'd1);
        step(1'b1, 1'b1, 1'b0, 8'h99);
        check("ovf_ptr", 32'(ptr), 32'(SS));
        check("ovf_top", 32'(mem_at(SS - 1)), 32'(SS));
        step(1'b1, 1'b1, 1'b1, 8'hEE);
        check("fpp_ptr",  32'(ptr), 32'(SS));
        check("fpp_top",  32'(mem_at(SS - 1)), 32'(SS));
        check("fpp_dout", 32'(data_out), 32'h00);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check("fpop_dout", 32'(data_out), 32'(SS));
        check("fpop_ptr",  32'(ptr), 32'(SS - 1));

        // Idle cycles hold everything
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("idle_dout", 32'(data_out), 32'(SS));
        check("idle_ptr",  32'(ptr), 32'(SS - 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_lifo_stack
`default_nettype wire
